// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module  : alu_seq_pkg
//  Brief   : Shared constants and helpers for the ALU operation sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int FSEL_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    localparam int                 OPCNT_W   = 16;
    localparam logic [OPCNT_W-1:0] OPCNT_MAX = 16'hFFFF;

    // Saturating increment: the completed-operation count never wraps.
    function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
        return (v == OPCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter2.sv
// ============================================================================
//  Module  : alu_rr_arbiter2
//  Brief   : Combinational two-way round-robin arbiter; pointer owned by parent.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter2
    import alu_seq_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    // A lone requester always wins; the pointer only breaks ties.
    assign grant_o[0] = valid_i[0] & (~valid_i[1] | (ptr_i == REQ_ID0));
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | (ptr_i == REQ_ID1));
    assign winner_o   = grant_o[1] ? REQ_ID1 : REQ_ID0;

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module  : alu_op_sequencer
//  Brief   : Shares one combinational ALU between two requesters with RR grant.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic                REQ0_VALID,
    output logic                REQ0_READY,
    input  logic [WIDTH-1:0]    REQ0_A,
    input  logic [WIDTH-1:0]    REQ0_B,
    input  logic [FSEL_W-1:0]   REQ0_F,

    input  logic                REQ1_VALID,
    output logic                REQ1_READY,
    input  logic [WIDTH-1:0]    REQ1_A,
    input  logic [WIDTH-1:0]    REQ1_B,
    input  logic [FSEL_W-1:0]   REQ1_F,

    output logic                RSP_VALID,
    input  logic                RSP_READY,
    output logic                RSP_ID,
    output logic [WIDTH-1:0]    RSP_Q,
    output logic                RSP_CARRY,

    output logic [WIDTH-1:0]    ALU_A,
    output logic [WIDTH-1:0]    ALU_B,
    output logic                ALU_F0,
    output logic                ALU_F1,
    output logic                ALU_F2,
    output logic                ALU_F3,
    input  logic [WIDTH-1:0]    ALU_Q,
    input  logic                ALU_CARRY,

    output logic                BUSY,
    output logic [OPCNT_W-1:0]  OP_COUNT
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0]          state_q,     state_d;
    logic                ptr_q,       ptr_d;
    logic [WIDTH-1:0]    opa_q,       opa_d;
    logic [WIDTH-1:0]    opb_q,       opb_d;
    logic [FSEL_W-1:0]   opf_q,       opf_d;
    logic                id_q,        id_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0]    rsp_q_q,     rsp_q_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [OPCNT_W-1:0]  op_count_q,  op_count_d;

    logic [1:0]          grant;
    logic                winner;
    logic                idle;

    alu_rr_arbiter2 u_arb (
        .valid_i  ({REQ1_VALID, REQ0_VALID}),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    assign idle = (state_q == ST_IDLE);

    // READY is masked by reset so nothing is offered while RST_N is low.
    assign REQ0_READY = idle & grant[0] & RST_N;
    assign REQ1_READY = idle & grant[1] & RST_N;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opf_d       = opf_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_carry_d = rsp_carry_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    opa_d   = (winner == REQ_ID1) ? REQ1_A : REQ0_A;
                    opb_d   = (winner == REQ_ID1) ? REQ1_B : REQ0_B;
                    opf_d   = (winner == REQ_ID1) ? REQ1_F : REQ0_F;
                    id_d    = winner;
                    cnt_d   = CNT_INIT;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_q_d     = ALU_Q;
                    rsp_carry_d = ALU_CARRY;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    op_count_d  = sat_inc(op_count_q);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= REQ_ID0;
            opa_q       <= '0;
            opb_q       <= '0;
            opf_q       <= '0;
            id_q        <= REQ_ID0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ_ID0;
            rsp_q_q     <= '0;
            rsp_carry_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opf_q       <= opf_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_carry_q <= rsp_carry_d;
            op_count_q  <= op_count_d;
        end
    end

    assign ALU_A     = opa_q;
    assign ALU_B     = opb_q;
    assign ALU_F0    = opf_q[0];
    assign ALU_F1    = opf_q[1];
    assign ALU_F2    = opf_q[2];
    assign ALU_F3    = opf_q[3];

    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_Q     = rsp_q_q;
    assign RSP_CARRY = rsp_carry_q;

    assign BUSY      = ~idle;
    assign OP_COUNT  = op_count_q;

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Shares one 8-bit combinational ALU (inputs A, B, F0..F3; outputs Q, Carry) between two requesters.
- Each requester submits operand/function transactions over a valid/ready handshake. A 2-way round-robin arbiter grants one request at a time.
- The block registers the operands and drives the ALU for a programmable settle time. It then captures Q/Carry and returns them on a single shared response channel, tagged with the requester ID.
- Position: sits between the requester logic (e.g. the command decoder) and the ALU instance.

Parameters:
- WIDTH, 8: operand and result width.
- EXEC_CYCLES, 1: cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, active-low.
- REQ0_VALID  in  1  requester 0 has a transaction.
- REQ0_READY  out  1  requester 0 transaction accepted this cycle.
- REQ0_A, REQ0_B  in  WIDTH  requester 0 operands.
- REQ0_F  in  4  requester 0 function select; bit0 maps to F0 … bit3 maps to F3.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_F  same as the requester 0 ports, for requester 1.
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer accepts result.
- RSP_ID  out  1  requester that issued the result.
- RSP_Q  out  WIDTH  captured ALU Q.
- RSP_CARRY  out  1  captured ALU Carry.
- ALU_A, ALU_B  out  WIDTH  to ALU A/B.
- ALU_F0, ALU_F1, ALU_F2, ALU_F3  out  1 each  to ALU function inputs.
- ALU_Q  in  WIDTH  from ALU Q.
- ALU_CARRY  in  1  from ALU Carry.
- BUSY  out  1  high in EXEC or RESP.
- OP_COUNT  out  16  completed-transaction counter.

Behaviour:
- Clocking: one clock (CLK). Reset is asynchronous and active-low (RST_N); all state is cleared on assertion and released synchronously with CLK.
- Reset values:
  - state = IDLE; round-robin pointer = 0, so requester 0 has priority first.
  - All ALU_* outputs 0.
  - RSP_VALID = 0, RSP_ID = 0, RSP_Q = 0, RSP_CARRY = 0.
  - BUSY = 0, OP_COUNT = 0.
  - Both READY signals 0.
- IDLE state:
  - Winner: if exactly one REQn_VALID is high, that requester wins. If both are high, the requester indicated by the pointer wins.
  - REQn_READY is combinational: high only for the winner, only while in IDLE.
  - On a valid&&ready edge: latch A/B/F into the operand registers, store the winner ID, load the settle counter with EXEC_CYCLES-1, go to EXEC.
  - With no valid request, remain in IDLE; ALU_* hold their last values.
- EXEC state:
  - ALU_A/B/F0..F3 are driven from the operand registers and are stable for exactly EXEC_CYCLES cycles.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture ALU_Q → RSP_Q, ALU_CARRY → RSP_CARRY, ID → RSP_ID; set RSP_VALID; go to RESP.
- RESP state:
  - RSP_* are held stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_VALID && RSP_READY: clear RSP_VALID, set pointer to the other requester (not RSP_ID), OP_COUNT += 1, go to IDLE.
  - RSP_Q/RSP_CARRY/RSP_ID retain their values after the handshake.
- Latency and throughput:
  - Request accepted at edge k → RSP_VALID high after edge k+EXEC_CYCLES.
  - Minimum request-to-request spacing is EXEC_CYCLES+2 cycles (IDLE, EXEC…, RESP).
- Protocol rules:
  - No new request is accepted while BUSY=1.
  - Requesters must hold VALID and payload stable until READY.
  - Payload changes after acceptance do not affect the operation in flight.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…. The pointer advances only on response completion.
- OP_COUNT saturates at 16'hFFFF; it never wraps.
- Reset mid-operation: the in-flight transaction is discarded and no response is produced. After reset release, the block returns to IDLE with the pointer at 0.
- BUSY = (state != IDLE).

Decomposition:
- Shared package alu_seq_pkg:
  - State encoding constants: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Function-select width FSEL_W=4.
  - Requester ID constants REQ_ID0=1'b0, REQ_ID1=1'b1.
  - OP_COUNT width 16 and saturation value.
- One sub-module, alu_rr_arbiter2:
  - Inputs: two valids and the pointer. Outputs: grant vector and winner ID.
  - Purely combinational.
  - Pointer register stays in the parent FSM.

Test Plan:
- The bench uses a stub ALU: F=4'h0 computes {Carry,Q}=A+B; F=4'h1 computes Q=~A, Carry=0.
- Single op, EXEC_CYCLES=1: REQ0 A=8'hF0, B=8'h20, F=0, RSP_READY=1 → RSP_VALID one cycle after accept; RSP_Q=8'h10, RSP_CARRY=1, RSP_ID=0; OP_COUNT=1.
- Contention: REQ0 and REQ1 both valid from reset, each issuing 4 ops → accept order 0,1,0,1,0,1,0,1; never two READYs in one cycle; OP_COUNT=8.
- Backpressure: REQ1 A=8'h5A, F=1, RSP_READY low for 10 cycles → RSP_Q=8'hA5 held stable throughout; REQ0_READY stays 0 while REQ0_VALID=1; REQ0 is accepted only after the response handshake.
- Settle time, EXEC_CYCLES=4: ALU_A/ALU_B/ALU_F* stable for exactly 4 cycles; capture occurs on the 4th cycle; RSP_VALID rises 4 cycles after accept.
- Reset mid-EXEC: assert RST_N=0 asynchronously during EXEC → all outputs return to reset values immediately; no response appears after release; next REQ1-only request is granted normally.
- Saturation: preload/force OP_COUNT=16'hFFFE, complete 3 ops → OP_COUNT = 16'hFFFF, not 16'h0001.
